// File: rtl/tri_raster_scan.sv
// tri_raster_scan
// Scan controller that sits in front of the point-in-triangle test stage.
// It latches a triangle on start and computes the triangle's bounding box,
// clipped to the screen. It then walks that box row-major on Px/Py and
// collects the stage's verdict, which arrives one cycle late. Each
// (x, y, inside) result is handed downstream over a valid/ready handshake.
//
// Ports
//   CLOCK_50, RESET_N      clock, async active-low reset
//   start, t_p1x..t_p3y    triangle request (sampled only when idle)
//   p1x..p3y               latched triangle to the test stage
//   Px, Py                 candidate pixel to the test stage
//   saida                  test stage verdict for the previous cycle's Px/Py
//   pix_valid/ready/x/y/inside  pixel result handshake
//   busy, done, inside_cnt status
//
// state  | meaning
// IDLE   | waiting for start
// BBOX   | compute clipped bounding box, seed Px/Py
// SETTLE | Px/Py stable, test stage registers its verdict
// EMIT   | verdict valid, present/retire current pixel
// FIN    | one-cycle done pulse
module tri_raster_scan #(
    parameter int CW          = 11,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int ONLY_INSIDE = 0,
    parameter int NW          = 20
) (
    input  logic          CLOCK_50,
    input  logic          RESET_N,
    input  logic          start,
    input  logic [CW-1:0] t_p1x,
    input  logic [CW-1:0] t_p1y,
    input  logic [CW-1:0] t_p2x,
    input  logic [CW-1:0] t_p2y,
    input  logic [CW-1:0] t_p3x,
    input  logic [CW-1:0] t_p3y,
    output logic [CW-1:0] p1x,
    output logic [CW-1:0] p1y,
    output logic [CW-1:0] p2x,
    output logic [CW-1:0] p2y,
    output logic [CW-1:0] p3x,
    output logic [CW-1:0] p3y,
    output logic [CW-1:0] Px,
    output logic [CW-1:0] Py,
    input  logic          saida,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          pix_inside,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] inside_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_BBOX, S_SETTLE, S_EMIT, S_FIN} state_t;

    localparam logic [CW-1:0] X_LAST = CW'(H_RES - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(V_RES - 1);
    // One bit wider so the screen size itself is representable for the empty test.
    localparam logic [CW:0]   H_LIM  = (CW+1)'(H_RES);
    localparam logic [CW:0]   V_LIM  = (CW+1)'(V_RES);

    state_t        state_q, state_d;
    logic [CW-1:0] p1x_q, p1y_q, p2x_q, p2y_q, p3x_q, p3y_q;
    logic [CW-1:0] p1x_d, p1y_d, p2x_d, p2y_d, p3x_d, p3y_d;
    logic [CW-1:0] px_q, py_q, px_d, py_d;
    logic [CW-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
    logic [CW-1:0] xmin_d, xmax_d, ymin_d, ymax_d;
    logic          busy_q, busy_d;
    logic [NW-1:0] cnt_q, cnt_d;

    logic [CW-1:0] bx_min, bx_max, by_min, by_max;
    logic          retire;

    function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, b, c);
        logic [CW-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, b, c);
        logic [CW-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    always_comb begin
        bx_min = min3(p1x_q, p2x_q, p3x_q);
        bx_max = max3(p1x_q, p2x_q, p3x_q);
        by_min = min3(p1y_q, p2y_q, p3y_q);
        by_max = max3(p1y_q, p2y_q, p3y_q);
    end

    always_comb begin
        state_d    = state_q;
        p1x_d      = p1x_q;
        p1y_d      = p1y_q;
        p2x_d      = p2x_q;
        p2y_d      = p2y_q;
        p3x_d      = p3x_q;
        p3y_d      = p3y_q;
        px_d       = px_q;
        py_d       = py_q;
        xmin_d     = xmin_q;
        xmax_d     = xmax_q;
        ymin_d     = ymin_q;
        ymax_d     = ymax_q;
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        pix_valid  = 1'b0;
        pix_inside = 1'b0;
        done       = 1'b0;
        retire     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    p1x_d   = t_p1x;
                    p1y_d   = t_p1y;
                    p2x_d   = t_p2x;
                    p2y_d   = t_p2y;
                    p3x_d   = t_p3x;
                    p3y_d   = t_p3y;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_BBOX;
                end
            end
            S_BBOX: begin
                xmin_d = bx_min;
                ymin_d = by_min;
                xmax_d = (bx_max > X_LAST) ? X_LAST : bx_max;
                ymax_d = (by_max > Y_LAST) ? Y_LAST : by_max;
                if (({1'b0, bx_min} >= H_LIM) || ({1'b0, by_min} >= V_LIM)) begin
                    state_d = S_FIN;
                end else begin
                    px_d    = bx_min;
                    py_d    = by_min;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                state_d = S_EMIT;
            end
            S_EMIT: begin
                pix_valid  = (ONLY_INSIDE == 0) ? 1'b1 : saida;
                pix_inside = saida;
                // Filtered-out pixels retire without waiting on downstream.
                retire     = pix_ready | ~pix_valid;
                if (retire) begin
                    if (saida && (cnt_q != '1)) begin
                        cnt_d = cnt_q + NW'(1);
                    end
                    if (px_q == xmax_q) begin
                        if (py_q == ymax_q) begin
                            state_d = S_FIN;
                        end else begin
                            px_d    = xmin_q;
                            py_d    = py_q + CW'(1);
                            state_d = S_SETTLE;
                        end
                    end else begin
                        px_d    = px_q + CW'(1);
                        state_d = S_SETTLE;
                    end
                end
            end
            S_FIN: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            p1x_q   <= '0;
            p1y_q   <= '0;
            p2x_q   <= '0;
            p2y_q   <= '0;
            p3x_q   <= '0;
            p3y_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            p1x_q   <= p1x_d;
            p1y_q   <= p1y_d;
            p2x_q   <= p2x_d;
            p2y_q   <= p2y_d;
            p3x_q   <= p3x_d;
            p3y_q   <= p3y_d;
            px_q    <= px_d;
            py_q    <= py_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign p1x        = p1x_q;
    assign p1y        = p1y_q;
    assign p2x        = p2x_q;
    assign p2y        = p2y_q;
    assign p3x        = p3x_q;
    assign p3y        = p3y_q;
    assign Px         = px_q;
    assign Py         = py_q;
    assign pix_x      = px_q;
    assign pix_y      = py_q;
    assign busy       = busy_q;
    assign inside_cnt = cnt_q;

endmodule

// File: tb/tb_tri_raster_scan.sv
// Bench for tri_raster_scan: a behavioural point-in-triangle stage drives
// saida, and every scan is checked against a raster list built from the
// clipped bounding box.
module tb_tri_raster_scan;

    localparam int CW = 11;
    localparam int NW = 20;

    logic          CLOCK_50 = 1'b0;
    logic          RESET_N  = 1'b0;
    logic          start    = 1'b0;
    logic [CW-1:0] t_p1x = '0, t_p1y = '0, t_p2x = '0, t_p2y = '0, t_p3x = '0, t_p3y = '0;
    logic [CW-1:0] p1x, p1y, p2x, p2y, p3x, p3y, Px, Py, pix_x, pix_y;
    logic          saida     = 1'b0;
    logic          pix_ready = 1'b0;
    logic          pix_valid, pix_inside, busy, done;
    logic [NW-1:0] inside_cnt;

    tri_raster_scan #(.CW(CW), .H_RES(640), .V_RES(480), .ONLY_INSIDE(0), .NW(NW)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .start     (start),
        .t_p1x     (t_p1x),
        .t_p1y     (t_p1y),
        .t_p2x     (t_p2x),
        .t_p2y     (t_p2y),
        .t_p3x     (t_p3x),
        .t_p3y     (t_p3y),
        .p1x       (p1x),
        .p1y       (p1y),
        .p2x       (p2x),
        .p2y       (p2y),
        .p3x       (p3x),
        .p3y       (p3y),
        .Px        (Px),
        .Py        (Py),
        .saida     (saida),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_inside(pix_inside),
        .busy      (busy),
        .done      (done),
        .inside_cnt(inside_cnt)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inclusive edge-function test, same sign on all three edges.
    function automatic bit in_tri(input int x1, y1, x2, y2, x3, y3, px, py);
        longint d1, d2, d3;
        d1 = longint'(px - x1) * (y2 - y1) - longint'(x2 - x1) * (py - y1);
        d2 = longint'(px - x2) * (y3 - y2) - longint'(x3 - x2) * (py - y2);
        d3 = longint'(px - x3) * (y1 - y3) - longint'(x1 - x3) * (py - y3);
        return (d1 >= 0 && d2 >= 0 && d3 >= 0) || (d1 <= 0 && d2 <= 0 && d3 <= 0);
    endfunction

    // Registered test stage: verdict for this cycle's Px/Py appears next cycle.
    always @(posedge CLOCK_50)
        saida <= in_tri(int'(p1x), int'(p1y), int'(p2x), int'(p2y), int'(p3x), int'(p3y),
                        int'(Px), int'(Py));

    // Downstream: drive ready, check stall stability, record handshakes.
    int            ready_mode = 0;
    int            rcnt = 0;
    logic [31:0]   got[$];
    logic          stall_prev = 1'b0;
    logic [CW-1:0] sx, sy;
    logic          sins;

    always @(negedge CLOCK_50) begin
        case (ready_mode)
            0: pix_ready = 1'b1;
            1: begin
                pix_ready = (rcnt == 0);
                rcnt = (rcnt + 1) % 3;
            end
            default: pix_ready = 1'($urandom_range(0, 1));
        endcase
        if (!RESET_N) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(pix_valid), 32'd1);
                chk("stall_xyi", {pix_x, pix_y, pix_inside}, {sx, sy, sins});
            end
            if (pix_valid && pix_ready) got.push_back({pix_x, pix_y, pix_inside});
            stall_prev = pix_valid && !pix_ready;
            sx   = pix_x;
            sy   = pix_y;
            sins = pix_inside;
        end
    end

    task automatic run_tri(input string tag, input int x1, y1, x2, y2, x3, y3, input int mode);
        logic [31:0] exp_q[$];
        int xmin, xmax, ymin, ymax, n_in, n, first;
        bit b;
        xmin = (x1 < x2) ? x1 : x2;  xmin = (x3 < xmin) ? x3 : xmin;
        xmax = (x1 > x2) ? x1 : x2;  xmax = (x3 > xmax) ? x3 : xmax;
        ymin = (y1 < y2) ? y1 : y2;  ymin = (y3 < ymin) ? y3 : ymin;
        ymax = (y1 > y2) ? y1 : y2;  ymax = (y3 > ymax) ? y3 : ymax;
        if (xmax > 639) xmax = 639;
        if (ymax > 479) ymax = 479;
        n_in = 0;
        if (xmin < 640 && ymin < 480) begin
            for (int y = ymin; y <= ymax; y++) begin
                for (int x = xmin; x <= xmax; x++) begin
                    b = in_tri(x1, y1, x2, y2, x3, y3, x, y);
                    if (b) n_in++;
                    exp_q.push_back({CW'(x), CW'(y), b});
                end
            end
        end

        ready_mode = mode;
        rcnt = 0;
        got.delete();
        @(negedge CLOCK_50);
        t_p1x = CW'(x1); t_p1y = CW'(y1);
        t_p2x = CW'(x2); t_p2y = CW'(y2);
        t_p3x = CW'(x3); t_p3y = CW'(y3);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        n = 1;
        first = -1;
        chk({tag, "_busy_on"}, 32'(busy), 32'd1);
        chk({tag, "_latch"}, {p1x, p2y, p3x}, {CW'(x1), CW'(y2), CW'(x3)});
        while (!done && n < 4000) begin
            if (pix_valid && first < 0) first = n;
            @(negedge CLOCK_50);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        if (mode == 0)
            chk({tag, "_done_time"}, 32'(n),
                (exp_q.size() == 0) ? 32'd2 : 32'(2 * exp_q.size() + 2));
        chk({tag, "_first_valid"}, 32'(first), (exp_q.size() == 0) ? 32'hFFFF_FFFF : 32'd3);
        @(negedge CLOCK_50);
        chk({tag, "_busy_off"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_npix"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk({tag, "_pix"}, got[i], exp_q[i]);
        chk({tag, "_inside_cnt"}, 32'(inside_cnt), 32'(n_in));
    endtask

    initial begin
        int a, b, c, d, e, f;

        #3;
        chk("rst_outs", {Px, Py, p1x, p3y, pix_x, pix_y}, 32'd0);
        chk("rst_flags", {pix_valid, pix_inside, busy, done, 8'd0, inside_cnt}, 32'd0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;

        run_tri("t1", 0, 0, 4, 0, 0, 4, 0);
        run_tri("t2", 0, 0, 4, 0, 0, 4, 1);
        run_tri("t3", 10, 10, 10, 10, 10, 10, 0);
        run_tri("t4", 700, 10, 800, 20, 900, 30, 0);
        run_tri("t5", 630, 470, 700, 470, 630, 500, 0);
        run_tri("t5r", 630, 470, 700, 470, 630, 500, 2);
        run_tri("ybig", 5, 500, 6, 600, 7, 700, 0);
        run_tri("colin", 2, 1, 5, 4, 8, 7, 1);

        // Reset in the middle of a scan, then rescan the same triangle.
        ready_mode = 0;
        @(negedge CLOCK_50);
        t_p1x = 11'd3; t_p1y = 11'd2; t_p2x = 11'd9; t_p2y = 11'd2; t_p3x = 11'd3; t_p3y = 11'd8;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (20) @(negedge CLOCK_50);
        #2 RESET_N = 1'b0;
        #1;
        chk("t6_rst_outs", {Px, Py, p1x, p2x, pix_x, pix_y}, 32'd0);
        chk("t6_rst_flags", {pix_valid, pix_inside, busy, done, 8'd0, inside_cnt}, 32'd0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        run_tri("t6", 3, 2, 9, 2, 3, 8, 0);

        for (int k = 0; k < 6; k++) begin
            a = $urandom_range(0, 12); b = $urandom_range(0, 12);
            c = $urandom_range(0, 12); d = $urandom_range(0, 12);
            e = $urandom_range(0, 12); f = $urandom_range(0, 12);
            run_tri("rnd", a, b, c, d, e, f, 2);
        end
        for (int k = 0; k < 3; k++) begin
            a = $urandom_range(628, 660); b = $urandom_range(470, 500);
            c = $urandom_range(628, 660); d = $urandom_range(470, 500);
            e = $urandom_range(628, 660); f = $urandom_range(470, 500);
            run_tri("edge", a, b, c, d, e, f, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
